generic_mlab_fifo: RTL and testbench
====================================

Name: generic_mlab_fifo

Overview:
Single-clock, parametrised first-word-fall-through FIFO. Storage is an MLAB-style RAM with a registered read port, plus a one-entry prefetch/output stage. It is the standard buffering element for AXI/USB slave datapaths, replacing hand-wired RAM-plus-pointer logic. It adds occupancy count, programmable almost-full/almost-empty flags, a synchronous flush and sticky overflow detection.

Parameters:
WIDTH, 8, data width in bits
ADDR_WIDTH, 5, RAM address width; RAM holds DEPTH = 2**ADDR_WIDTH words
AFULL_THRESH, DEPTH-2, almost_full asserted when count >= AFULL_THRESH
AEMPTY_THRESH, 2, almost_empty asserted when count <= AEMPTY_THRESH

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous flush; discards all contents
wr_en  in  1  write request
wr_data  in  WIDTH  write data
full  out  1  no write accepted this cycle
almost_full  out  1  count >= AFULL_THRESH
rd_valid  out  1  rd_data holds the oldest entry
rd_ready  in  1  consumer accepts rd_data when rd_valid=1
rd_data  out  WIDTH  head-of-queue data, registered
almost_empty  out  1  count <= AEMPTY_THRESH
count  out  ADDR_WIDTH+1  total entries held (RAM + in-flight read + output stage)
overflow  out  1  sticky: a write was attempted while full

Behaviour:
- Reset (rst_n=0, async): pointers=0, count=0, full=0, almost_full=0, rd_valid=0, rd_data=0, almost_empty=1, overflow=0. RAM contents are not reset.
- Capacity is exactly DEPTH entries, counted across RAM, the in-flight RAM read and the output register. full = (count == DEPTH), driven from registers only.
- Write accept: wr_en && !full. Data is written to RAM[wptr], wptr increments mod DEPTH, and count increments.
- Write attempt while full: data is dropped, pointers and count are unchanged, and overflow is set. overflow holds until clr or reset.
- Read accept: rd_valid && rd_ready. count decrements. The output stage reloads from the prefetched RAM word if one is available; otherwise rd_valid falls next cycle.
- RAM read is registered, 1 cycle. Prefetch issues a RAM read (rptr increments) whenever the RAM holds an unread word and the output stage is empty, is being emptied this cycle, or is about to be. Back-to-back reads sustain 1 word/cycle with no bubbles when count >= 2.
- Latency: a word written at edge k into an empty FIFO gives rd_valid=1 and rd_data=word after edge k+2. count reflects the write after edge k.
- rd_data and rd_valid are stable while rd_valid=1 and rd_ready=0.
- Simultaneous accepted write and read: count is unchanged. When full, a read in the same cycle does not permit the write (full is registered), so overflow is set if wr_en=1.
- Write to empty with rd_ready=1: no combinational bypass; minimum latency of 2 still applies.
- Pointer wrap: wptr and rptr wrap DEPTH-1 -> 0 with no loss. count never exceeds DEPTH and never goes below 0.
- clr: at the next edge the block takes reset values, except RAM contents are kept. clr has priority over wr_en and rd_ready in the same cycle.
- Reset or clr mid-stream: an in-flight RAM read is discarded and rd_valid=0 afterwards.
- almost_full and almost_empty are combinational compares on the registered count, with no extra latency.

Test Plan:
- Reset then idle -> count=0, rd_valid=0, almost_empty=1, full=0, overflow=0.
- Write 0x11 at one edge, rd_ready=0 -> count=1 next cycle. rd_valid=1 with rd_data=0x11 two edges after the write, held stable for 5 cycles.
- Write 32 words 0x00..0x1F (ADDR_WIDTH=5), then rd_ready=1 -> full=1 after the 32nd write and almost_full from count=30. Reads return 0x00..0x1F in order on consecutive cycles; count steps to 0.
- With FIFO full, wr_en=1 and rd_ready=1 for one cycle -> the write is dropped, overflow=1, count=31. overflow stays 1 until clr.
- Continuous simultaneous write/read at count=5 for 100 cycles across pointer wrap -> count stays 5 and the data sequence is intact.
- clr asserted at count=10 together with wr_en -> next cycle count=0, rd_valid=0, overflow=0. A write then reads back correctly after 2 cycles.

Source files
------------

// File: rtl/generic_mlab_fifo.sv
// generic_mlab_fifo: single-clock first-word-fall-through FIFO.
// An MLAB-style RAM with a registered read port feeds a prefetch register,
// which in turn feeds a one-entry output stage. The occupancy count covers all
// three places a word can live, so capacity is exactly DEPTH words.
module generic_mlab_fifo #(
  parameter int WIDTH         = 8,
  parameter int ADDR_WIDTH    = 5,
  parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  // Storage array; contents survive reset and flush.
  logic [WIDTH-1:0]      mem [DEPTH];

  // Pointers and occupancy bookkeeping.
  logic [ADDR_WIDTH-1:0] wptr_q,   wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q,   rptr_d;
  logic [ADDR_WIDTH:0]   unread_q, unread_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;

  // Prefetch register (the RAM's registered read port) and output stage.
  logic                  pf_valid_q,  pf_valid_d;
  logic [WIDTH-1:0]      pf_data_q;
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_data_q,  out_data_d;

  logic                  overflow_q,  overflow_d;

  // Handshake and pipeline movement strobes.
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  pf_move;
  logic                  rd_issue;

  // Flags are derived from registered state only, so no input reaches them.
  assign full         = (count_q == DEPTH_CNT);
  assign almost_full  = (count_q >= AFULL_CNT);
  assign almost_empty = (count_q <= AEMPTY_CNT);
  assign count        = count_q;
  assign rd_valid     = out_valid_q;
  assign rd_data      = out_data_q;
  assign overflow     = overflow_q;

  // A write is taken only when not full; a read only when the head is presented.
  // The prefetched word moves forward whenever the output stage is empty or being
  // emptied, and a new RAM read is launched whenever the prefetch register will be
  // free at the next edge, which keeps reads streaming at one word per cycle.
  always_comb begin
    wr_accept = wr_en && !full;
    rd_accept = out_valid_q && rd_ready;
    pf_move   = pf_valid_q && (!out_valid_q || rd_accept);
    rd_issue  = (unread_q != '0) && (!pf_valid_q || pf_move);
  end

  // Next-state computation for pointers, counters, pipeline stages and flags.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    unread_d    = unread_q;
    count_d     = count_q;
    pf_valid_d  = pf_valid_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;

    if (clr) begin
      wptr_d      = '0;
      rptr_d      = '0;
      unread_d    = '0;
      count_d     = '0;
      pf_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      overflow_d  = 1'b0;
    end else begin
      if (wr_accept) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (rd_issue) begin
        rptr_d = rptr_q + 1'b1;
      end

      unique case ({wr_accept, rd_issue})
        2'b10:   unread_d = unread_q + 1'b1;
        2'b01:   unread_d = unread_q - 1'b1;
        default: unread_d = unread_q;
      endcase

      unique case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      if (rd_issue) begin
        pf_valid_d = 1'b1;
      end else if (pf_move) begin
        pf_valid_d = 1'b0;
      end

      if (pf_move) begin
        out_valid_d = 1'b1;
        out_data_d  = pf_data_q;
      end else if (rd_accept) begin
        out_valid_d = 1'b0;
      end

      if (wr_en && full) begin
        overflow_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      unread_q    <= '0;
      count_q     <= '0;
      pf_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      unread_q    <= unread_d;
      count_q     <= count_d;
      pf_valid_q  <= pf_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // RAM write port; a flush in the same cycle drops the write.
  always_ff @(posedge clk) begin
    if (wr_accept && !clr) begin
      mem[wptr_q] <= wr_data;
    end
  end

  // Registered RAM read port; its valid bit lives in pf_valid_q.
  always_ff @(posedge clk) begin
    if (rd_issue) begin
      pf_data_q <= mem[rptr_q];
    end
  end

endmodule

// File: tb/tb_generic_mlab_fifo.sv
// Self-checking bench for generic_mlab_fifo: directed steps plus random traffic
// compared against a queue-based model of the FIFO's observable behaviour.
module tb_generic_mlab_fifo;

  localparam int W     = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int AF    = 30;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          full;
  logic          almost_full;
  logic          rd_valid;
  logic          rd_ready;
  logic [W-1:0]  rd_data;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  // Model: queued data with the edge index at which each word was written.
  int  dataQ[$];
  int  timeQ[$];
  int  edgeCnt = 0;
  bit  ovModel = 1'b0;

  generic_mlab_fifo #(
    .WIDTH(W), .ADDR_WIDTH(AW), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .almost_full(almost_full), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .almost_empty(almost_empty),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The head is presented once it was written at least two edges ago.
  function automatic bit headVisible();
    if (dataQ.size() == 0) return 1'b0;
    return (edgeCnt - timeQ[0]) >= 2;
  endfunction

  task automatic checkOutput();
    int n;
    n = dataQ.size();
    check("count", 32'(count), 32'(n));
    check("rd_valid", 32'(rd_valid), 32'(headVisible()));
    if (headVisible()) check("rd_data", 32'(rd_data), 32'(dataQ[0]));
    check("full", 32'(full), 32'(n == DEPTH));
    check("almost_full", 32'(almost_full), 32'(n >= AF));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE));
    check("overflow", 32'(overflow), 32'(ovModel));
  endtask

  // Drive one cycle from the falling edge, check, then advance the model.
  task automatic applyStimulus(input bit w, input logic [W-1:0] d, input bit r, input bit c);
    bit vis;
    bit wasFull;
    wr_en    = w;
    wr_data  = d;
    rd_ready = r;
    clr      = c;
    checkOutput();
    vis     = headVisible();
    wasFull = (dataQ.size() == DEPTH);
    @(posedge clk);
    edgeCnt++;
    if (c) begin
      dataQ.delete();
      timeQ.delete();
      ovModel = 1'b0;
    end else begin
      if (vis && r) begin
        void'(dataQ.pop_front());
        void'(timeQ.pop_front());
      end
      if (w && wasFull) begin
        ovModel = 1'b1;
      end else if (w) begin
        dataQ.push_back(int'(d));
        timeQ.push_back(edgeCnt);
      end
    end
    @(negedge clk);
    wr_en    = 1'b0;
    rd_ready = 1'b0;
    clr      = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic doReset();
    #2 rst_n = 1'b0;
    dataQ.delete();
    timeQ.delete();
    ovModel = 1'b0;
    @(negedge clk);
    checkOutput();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    clr      = 1'b0;
    wr_en    = 1'b0;
    rd_ready = 1'b0;
    wr_data  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput();
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Single word, held while the consumer stalls.
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    repeat (7) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill to capacity, attempt a write while full with a read, then drain.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    repeat (DEPTH + 3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Steady occupancy of five across pointer wrap.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (100) applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0);

    // Flush at count ten together with a write, then a fresh write.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hAB, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic, alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 800; i++) begin
      bit w;
      bit r;
      bit c;
      if (((i / 100) % 2) == 0) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      c = ($urandom_range(0, 149) == 0);
      applyStimulus(w, 8'($urandom), r, c);
    end

    // Reset with data in flight, then confirm normal operation resumes.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h70 + i), 1'b1, 1'b0);
    doReset();
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
